ram_port_ctrl: RTL and testbench
================================

# ram_port_ctrl

Initiator-side controller for the single-port word RAM in the RISC datapath. Accepts load/store requests from the core over a valid/ready handshake and sequences the RAM's `write_enable`/`address`/`data` inputs. It captures the RAM's registered `data_out` one cycle after the read address is applied. Byte-masked stores become a read-modify-write (RMW), because the RAM has no byte enables.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width; matches RAM depth parameter
- `DATA_W`, 32, word width; fixed byte-mask width is `DATA_W/8`

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  core request valid
- `req_ready`  out  1  controller can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  word address
- `req_wdata`  in  DATA_W  store data
- `req_wmask`  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i]
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  core accepts response
- `rsp_rdata`  out  DATA_W  load data
- `ram_we`  out  1  to RAM `write_enable`
- `ram_addr`  out  ADDR_W  to RAM `address`
- `ram_wdata`  out  DATA_W  to RAM `data`
- `ram_rdata`  in  DATA_W  from RAM `data_out`

## Operation
- **Clock and reset:** one clock. Reset is synchronous and active-high: `clk` and `rst`, where `rst` is sampled only on the rising edge of `clk`.
- **Registered outputs:** all RAM-side outputs and `rsp_*` are registered. `req_ready` = (state == IDLE) && !rst.
- **States:** IDLE, RD_ISSUE, RD_CAPT, WR, RESP.
- **IDLE:**
  - On `req_valid && req_ready`, capture addr/wdata/wmask/we and set `ram_addr <= req_addr`.
  - Load: goes to RD_ISSUE.
  - Store with `wmask == all ones`: `ram_wdata <= req_wdata`, goes to WR.
  - Store with `wmask == 0`: goes straight to RESP with no RAM access.
  - Store with partial mask: goes to RD_ISSUE (RMW).
- **RD_ISSUE:** `ram_we = 0` and `ram_addr` is stable; the RAM loads `data_out` at the end of this cycle. Always goes to RD_CAPT.
- **RD_CAPT:** `ram_rdata` is valid.
  - Load: `rsp_rdata <= ram_rdata`, goes to RESP.
  - RMW: `ram_wdata <=` per-byte merge (mask bit 1 takes the `req_wdata` byte, 0 takes the `ram_rdata` byte), goes to WR.
- **WR:** `ram_we = 1` for exactly this one cycle; goes to RESP.
- **RESP:** `rsp_valid = 1`, held with `rsp_rdata` stable until `rsp_ready`. On `rsp_ready`, goes to IDLE.
  - Store responses leave `rsp_rdata` unchanged.
- **`ram_we`:** 0 in every state except WR. `ram_addr` and `ram_wdata` hold their last values when unused.
- **Reset:** while `rst` is high, state = IDLE and `req_ready = 0`. On reset, `rsp_valid = 0`, `rsp_rdata = 0`, `ram_we = 0`, `ram_addr = 0`, `ram_wdata = 0`.
- **Reset mid-operation:**
  - A WR cycle that coincides with `rst` still commits to the RAM, because the RAM samples `ram_we = 1` on that edge.
  - Any other in-flight request is dropped with no response.

## Timing
- Latency is counted from the accept cycle to the first cycle with `rsp_valid` high:
  - zero-mask store: 1
  - full store: 2
  - load: 3
  - RMW store: 4
- **Throughput:** one request in flight. The next accept is at the earliest the cycle after the `rsp_valid && rsp_ready` cycle.
- **Back-to-back:** a store followed by a load to the same address returns the new data, because the write commits before the next RAM read is issued.
- **Backpressure:** `rsp_ready` low stalls in RESP indefinitely; `req_ready` stays 0 during the stall.

## Configuration
- Macro: `RAM_PORT_CTRL_RMW_EN`.
- **Defined:** partial masks use the RMW path as described above.
- **Undefined:**
  - `req_wmask` is ignored.
  - Every store with `req_we = 1` is a full-word write: IDLE→WR→RESP, latency 2.
  - The zero-mask shortcut is also removed.

## Test plan
- Load after reset: RAM preloaded `addr 5 = 0xDEADBEEF` → accept at cycle c, `rsp_valid` at c+3 with `rsp_rdata = 0xDEADBEEF`, `ram_we = 0` throughout.
- Full store then load: write `0x12345678` to addr 3 with mask `0xF` → `ram_we` high for exactly one cycle, response at c+2; a subsequent load of addr 3 returns `0x12345678`.
- RMW (macro defined): RAM addr 7 = `0xAABBCCDD`, store `0x11223344` with mask `0b0101` → RAM word becomes `0xAA22CC44`, response at c+4.
- Zero mask / macro undefined:
  - mask 0 → response at c+1 with no `ram_we` pulse.
  - With the macro undefined, the same store writes `0x11223344` in full.
- Backpressure: hold `rsp_ready = 0` for 5 cycles → `rsp_valid` and `rsp_rdata` stable and `req_ready = 0`; release → IDLE next cycle, new request accepted.
- Reset mid-op:
  - Assert `rst` during RD_CAPT → no response, outputs return to reset values.
  - Assert `rst` during WR → the RAM word is still updated.

Source files
------------

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: load/store sequencer for a single-port word RAM with registered data_out.
// Define RAM_PORT_CTRL_RMW_EN to honour byte masks through read-modify-write; otherwise stores are full-word.
module ram_port_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR, RESP} state_e;
  state_e state_q, state_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d, ram_wdata_q, ram_wdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic rsp_valid_q, ram_we_q;
`ifdef RAM_PORT_CTRL_RMW_EN
  localparam int BW = DATA_W / 8;
  logic we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, merged;
  logic [BW-1:0] mask_q, mask_d;
  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < BW; i++)
      if (mask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end
`else
  logic unused_wmask;
  assign unused_wmask = ^req_wmask;
`endif
  always_comb begin
    state_d = state_q;
    rsp_rdata_d = rsp_rdata_q;
    ram_addr_d = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef RAM_PORT_CTRL_RMW_EN
    we_d = we_q;
    wdata_d = wdata_q;
    mask_d = mask_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        ram_addr_d = req_addr;
`ifdef RAM_PORT_CTRL_RMW_EN
        we_d = req_we;
        wdata_d = req_wdata;
        mask_d = req_wmask;
        if (!req_we) state_d = RD_ISSUE;
        else if (&req_wmask) begin
          ram_wdata_d = req_wdata;
          state_d = WR;
        end
        else state_d = (|req_wmask) ? RD_ISSUE : RESP;
`else
        if (req_we) ram_wdata_d = req_wdata;
        state_d = req_we ? WR : RD_ISSUE;
`endif
      end
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
`ifdef RAM_PORT_CTRL_RMW_EN
        if (we_q) begin
          ram_wdata_d = merged;
          state_d = WR;
        end else begin
          rsp_rdata_d = ram_rdata;
          state_d = RESP;
        end
`else
        rsp_rdata_d = ram_rdata;
        state_d = RESP;
`endif
      end
      WR: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // ram_we and rsp_valid are registered copies of the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
`ifdef RAM_PORT_CTRL_RMW_EN
      we_q <= 1'b0;
      wdata_q <= '0;
      mask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rsp_valid_q <= state_d == RESP;
      rsp_rdata_q <= rsp_rdata_d;
      ram_we_q <= state_d == WR;
      ram_addr_q <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef RAM_PORT_CTRL_RMW_EN
      we_q <= we_d;
      wdata_q <= wdata_d;
      mask_q <= mask_d;
`endif
    end
  end
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_we = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: directed table, random traffic against a word-array model, backpressure and reset corners.
module tb_ram_port_ctrl;
`ifdef RAM_PORT_CTRL_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [9:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_wmask = '0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic ram_we;
  logic [9:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic pl_en = 1'b0;
  logic [9:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_rd;
  int we_cnt = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ram_port_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM with registered data_out, plus a bench-side preload port
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic model_txn(input bit we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m,
                           output logic [31:0] er, output int el, output int ew);
    if (!we) begin
      last_rd = ref_mem[a];
      el = 3;
      ew = 0;
    end else if (!RMW) begin
      ref_mem[a] = d;
      el = 2;
      ew = 1;
    end else if (m == 4'h0) begin
      el = 1;
      ew = 0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      el = (m == 4'hF) ? 2 : 4;
      ew = 1;
    end
    er = last_rd;
  endtask

  task automatic do_req(input bit we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m,
                        input int stall, output logic [31:0] rd, output int lat, output int wes);
    int n, w0;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_wmask = m;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    w0 = we_cnt;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    rd = rsp_rdata;
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, rd);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("idle_after_rsp", 32'(req_ready), 32'd1);
    wes = we_cnt - w0;
  endtask

  typedef struct {
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wes;
  } vec_t;
  vec_t vt [9];

  initial begin
    logic [31:0] rd, er;
    int lat, wes, el, ew;
    bit we;
    logic [9:0] a;
    logic [31:0] d;
    logic [3:0] m;
    int sel;
    vt[0] = '{1'b0, 10'd5,    32'h0,        4'h0, 32'hDEADBEEF, 3, 0};
    vt[1] = '{1'b1, 10'd3,    32'h12345678, 4'hF, 32'hDEADBEEF, 2, 1};
    vt[2] = '{1'b0, 10'd3,    32'h0,        4'h0, 32'h12345678, 3, 0};
    vt[3] = '{1'b1, 10'd7,    32'h11223344, 4'h5, 32'h12345678, RMW ? 4 : 2, 1};
    vt[4] = '{1'b0, 10'd7,    32'h0,        4'h0, RMW ? 32'hAA22CC44 : 32'h11223344, 3, 0};
    vt[5] = '{1'b1, 10'd9,    32'h55667788, 4'h0, RMW ? 32'hAA22CC44 : 32'h11223344, RMW ? 1 : 2, RMW ? 0 : 1};
    vt[6] = '{1'b0, 10'd9,    32'h0,        4'h0, RMW ? 32'h0BADF00D : 32'h55667788, 3, 0};
    vt[7] = '{1'b1, 10'd1023, 32'hFFFFFFFF, 4'h8, RMW ? 32'h0BADF00D : 32'h55667788, RMW ? 4 : 2, 1};
    vt[8] = '{1'b0, 10'd1023, 32'h0,        4'h0, RMW ? 32'hFF000000 : 32'hFFFFFFFF, 3, 0};
    last_rd = '0;
    for (int i = 0; i < 16; i++) preload(10'(i), $urandom);
    preload(10'd5, 32'hDEADBEEF);
    preload(10'd7, 32'hAABBCCDD);
    preload(10'd9, 32'h0BADF00D);
    preload(10'd1023, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      model_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].mask, er, el, ew);
      do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].mask, 0, rd, lat, wes);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_we_pulses", i), wes, vt[i].exp_wes);
    end
    // Backpressure: load held in RESP for 5 cycles
    model_txn(1'b0, 10'd5, 32'h0, 4'h0, er, el, ew);
    do_req(1'b0, 10'd5, 32'h0, 4'h0, 5, rd, lat, wes);
    chk("bp_rdata", rd, 32'hDEADBEEF);
    chk("bp_latency", lat, 3);
    for (int t = 0; t < 150; t++) begin
      we = 1'($urandom_range(0, 1));
      a = 10'($urandom_range(0, 15));
      d = $urandom;
      sel = $urandom_range(0, 3);
      m = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom);
      model_txn(we, a, d, m, er, el, ew);
      do_req(we, a, d, m, $urandom_range(0, 2), rd, lat, wes);
      chk("rnd_rdata", rd, er);
      chk("rnd_latency", lat, el);
      chk("rnd_we_pulses", wes, ew);
    end
    // Reset during RD_CAPT drops the load
    req_we = 1'b0;
    req_addr = 10'd5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rdcapt_ram_addr", 32'(ram_addr), 32'd5);
    rst = 1'b1;
    tick();
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
    chk("midrst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    last_rd = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("midrst_idle", 32'(req_ready), 32'd1);
    // Reset during WR still commits the word
    req_we = 1'b1;
    req_addr = 10'd20;
    req_wdata = 32'hCAFEF00D;
    req_wmask = 4'hF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("wrrst_pulse", 32'(ram_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_mem[20] = 32'hCAFEF00D;
    chk("wrrst_mem", mem[20], 32'hCAFEF00D);
    chk("wrrst_ram_we", 32'(ram_we), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wrrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    model_txn(1'b0, 10'd20, 32'h0, 4'h0, er, el, ew);
    do_req(1'b0, 10'd20, 32'h0, 4'h0, 0, rd, lat, wes);
    chk("wrrst_readback", rd, er);
    chk("wrrst_latency", lat, el);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
